// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end for one shared combinational ALU.
// Requesters hand over operands through a valid/ready channel. The winner's
// operands are registered onto the ALU inputs. One cycle later the ALU result
// is captured and returned, tagged with the winner's index.
// Optional build macro ALU_ARB_STATS_EN adds the op_count output. op_count counts
// completed response handshakes and saturates at 16'hFFFF.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int SEL_W   = 2,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [SEL_W-1:0]          alu_sel,
    input  logic [DATA_W-1:0]         alu_out
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]               op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    // Index of the most recent grant; the search starts one past it.
    logic [ID_W-1:0] ptr;

    logic [DATA_W-1:0] a_arr   [NUM_REQ];
    logic [DATA_W-1:0] b_arr   [NUM_REQ];
    logic [SEL_W-1:0]  sel_arr [NUM_REQ];

    logic [2*NUM_REQ-1:0] dbl_valid;
    logic [2*NUM_REQ-1:0] shf_valid;
    logic [NUM_REQ-1:0]   rot_valid;
    logic                 any_valid;
    logic [ID_W-1:0]      grant;
    int                   off;
    int                   gsum;

    // Unpack the flat request buses into per-requester views.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i]   = req_a[i*DATA_W +: DATA_W];
            b_arr[i]   = req_b[i*DATA_W +: DATA_W];
            sel_arr[i] = req_sel[i*SEL_W +: SEL_W];
        end
    end

    // Round-robin pick. Rotate the valid vector so that bit 0 is requester
    // ptr+1, take the lowest set bit, then map that offset back to an index.
    always_comb begin
        dbl_valid = {req_valid, req_valid};
        shf_valid = dbl_valid >> (ptr + 1'b1);
        rot_valid = shf_valid[NUM_REQ-1:0];
        any_valid = |req_valid;
        off       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                off = i;
            end
        end
        gsum = int'(ptr) + 1 + off;
        if (gsum >= NUM_REQ) begin
            gsum = gsum - NUM_REQ;
        end
        grant = ID_W'(gsum);
    end

    // Accept only in IDLE. Held low while rst is asserted so that no
    // handshake can appear during reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && (state == IDLE) && any_valid && (grant == ID_W'(i));
        end
    end

    // Transaction FSM: capture operands, then the result, then hold the
    // response until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= ID_W'(NUM_REQ - 1);
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_a   <= a_arr[grant];
                        alu_b   <= b_arr[grant];
                        alu_sel <= sel_arr[grant];
                        rsp_id  <= grant;
                        ptr     <= grant;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Count response handshakes; stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if ((state == RESP) && rsp_ready && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. The bench supplies the shared ALU:
// sel 0 is add, 1 is subtract, 2 is AND and 3 is OR.
module tb_alu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 16;
    localparam int SEL_W   = 2;
    localparam int ID_W    = 1;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*SEL_W-1:0]  req_sel;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [SEL_W-1:0]          alu_sel;
    logic [DATA_W-1:0]         alu_out;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]               op_count;
`endif

    int total = 0;
    int bad   = 0;

    alu_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_sel  (req_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_id   (rsp_id),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out)
`ifdef ALU_ARB_STATS_EN
        ,
        .op_count (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU seen by the arbiter.
    always_comb begin
        case (alu_sel)
            2'd0:    alu_out = alu_a + alu_b;
            2'd1:    alu_out = alu_a - alu_b;
            2'd2:    alu_out = alu_a & alu_b;
            default: alu_out = alu_a | alu_b;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
        req_sel[i*SEL_W +: SEL_W] = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One full transaction starting in IDLE with the request already valid.
    task automatic run_op(input int id, input logic [15:0] exp_data, input string tag);
        check_val({tag, "_ready"}, req_ready, 32'(1 << id));
        tick();
        check_val({tag, "_exec_valid"}, rsp_valid, 0);
        tick();
        check_val({tag, "_valid"}, rsp_valid, 1);
        check_val({tag, "_data"}, rsp_data, exp_data);
        check_val({tag, "_id"}, rsp_id, id);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val({tag, "_done"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst_ready", req_ready, 0);
        check_val("rst_valid", rsp_valid, 0);
        check_val("rst_data", rsp_data, 0);
        check_val("rst_id", rsp_id, 0);
        check_val("rst_alu_a", alu_a, 0);
        check_val("rst_alu_b", alu_b, 0);
        check_val("rst_alu_sel", alu_sel, 0);
        rst = 1'b0;

        // Single op: 5 - 2 = 3 from requester 0
        set_req(0, 16'h0005, 16'h0002, 2'd1);
        req_valid = 2'b01;
        #1;
        check_val("t1_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        set_req(0, 16'hDEAD, 16'hBEEF, 2'd3);
        check_val("t1_alu_a", alu_a, 16'h0005);
        check_val("t1_alu_b", alu_b, 16'h0002);
        check_val("t1_alu_sel", alu_sel, 2'd1);
        check_val("t1_ready_exec", req_ready, 0);
        check_val("t1_exec_valid", rsp_valid, 0);
        tick();
        check_val("t1_valid", rsp_valid, 1);
        check_val("t1_data", rsp_data, 16'h0003);
        check_val("t1_id", rsp_id, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("t1_done", rsp_valid, 0);
        check_val("t1_alu_a_held", alu_a, 16'h0005);
`ifdef ALU_ARB_STATS_EN
        check_val("t1_op_count", op_count, 1);
`endif

        // Contention: requester 0 gives 10+3=13, requester 1 gives 20-6=14
        do_reset();
        set_req(0, 16'd10, 16'd3, 2'd0);
        set_req(1, 16'd20, 16'd6, 2'd1);
        req_valid = 2'b11;
        #1;
        run_op(0, 16'd13, "t2_op0");
        run_op(1, 16'd14, "t2_op1");
        run_op(0, 16'd13, "t2_op2");
        run_op(1, 16'd14, "t2_op3");
        req_valid = 2'b00;

        // Backpressure: 0x1234 & 0x0F0F = 0x0204 held for 5 cycles
        set_req(0, 16'h1234, 16'h0F0F, 2'd2);
        req_valid = 2'b01;
        #1;
        check_val("t3_ready", req_ready, 2'b01);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check_val("t3_hold_valid", rsp_valid, 1);
            check_val("t3_hold_data", rsp_data, 16'h0204);
            check_val("t3_hold_id", rsp_id, 0);
            check_val("t3_hold_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("t3_done", rsp_valid, 0);
        check_val("t3_next_ready", req_ready, 2'b01);
        set_req(0, 16'h0001, 16'h0001, 2'd0);
        tick();
        check_val("t3_next_alu_a", alu_a, 16'h0001);
        check_val("t3_next_ready_exec", req_ready, 0);

        // Reset during EXEC
        rst = 1'b1;
        #1;
        check_val("t4_ready", req_ready, 0);
        check_val("t4_valid", rsp_valid, 0);
        check_val("t4_data", rsp_data, 0);
        check_val("t4_id", rsp_id, 0);
        check_val("t4_alu_a", alu_a, 0);
        check_val("t4_alu_b", alu_b, 0);
        check_val("t4_alu_sel", alu_sel, 0);
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val("t4_quiet", rsp_valid, 0);
        end

        // All selects on requester 1 with A=5, B=2
        req_valid = 2'b10;
        set_req(1, 16'h0005, 16'h0002, 2'd0);
        #1;
        run_op(1, 16'h0007, "t5_add");
        set_req(1, 16'h0005, 16'h0002, 2'd1);
        run_op(1, 16'h0003, "t5_sub");
        set_req(1, 16'h0005, 16'h0002, 2'd2);
        run_op(1, 16'h0000, "t5_and");
        set_req(1, 16'h0005, 16'h0002, 2'd3);
        run_op(1, 16'h0007, "t5_or");
        req_valid = 2'b00;
        #1;
        check_val("t5_idle_ready", req_ready, 0);
        check_val("t5_alu_sel_held", alu_sel, 2'd3);
        check_val("t5_alu_a_held", alu_a, 16'h0005);
`ifdef ALU_ARB_STATS_EN
        check_val("t5_op_count", op_count, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
